odd_change_monitor: RTL and testbench
=====================================

# odd_change_monitor

Receive-side checker for the odd-ratio clock divider output. Samples the divided waveform on the system clock and measures each period's high phase, low phase and total length. Flags whether the period is odd and the duty is balanced, and declares lock once the period is stable. Sits downstream of the divider in the test and measurement path, and gives the bench and on-chip status logic a cycle-accurate view of `dout`.

## Interface
- `CNT_W`, 8: width of the phase counters; maximum countable phase length is 2^CNT_W-1 cycles.
- `LOCK_N`, 4: number of consecutive identical completed periods required to assert `locked`; legal range is 2..15.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `din`  in  1  divided waveform; same clock domain as `clk`, no synchronizer.
- `high_len`  out  CNT_W  high-phase length of the last completed period, in cycles.
- `low_len`  out  CNT_W  low-phase length of the last completed period, in cycles.
- `period`  out  CNT_W+1  `high_len + low_len`; no truncation.
- `period_vld`  out  1  one-cycle pulse when the length outputs update.
- `is_odd`  out  1  `period[0]`; valid with `period`.
- `balanced`  out  1  high when \|high_len − low_len\| ≤ 1.
- `locked`  out  1  `period` is stable.
- `err`  out  1  one-cycle pulse on a period change while locked, or on counter saturation.

## Operation
- `s` is `din` sampled at each `clk` edge. The FSM has four states: ARM, SYNC, HIGH, LOW.
- **ARM (reset state)**
  - Wait for `s=0`, then go to SYNC.
  - Discards any partial high phase after reset.
- **SYNC**
  - On `s=1`: go to HIGH, set `hi_cnt=1`, `lo_cnt=0`.
  - No report is made.
- **HIGH**
  - `s=1`: increment `hi_cnt`.
  - `s=0`: go to LOW, set `lo_cnt=1`.
- **LOW**
  - `s=0`: increment `lo_cnt`.
  - `s=1` completes a period. Register `high_len=hi_cnt`, `low_len=lo_cnt` and `period`, pulse `period_vld`, set `hi_cnt=1`, `lo_cnt=0`, go to HIGH.
- **Lock tracking** (evaluated only on completed periods)
  - `match_cnt` (4 bits) is set to 1 if the new period differs from the previous one; otherwise it increments, saturating at `LOCK_N`.
  - `locked` rises on the edge where `match_cnt` reaches `LOCK_N`.
  - While locked, a differing period drops `locked`, pulses `err` and sets `match_cnt=1`. All of this happens on the same edge as that period's `period_vld`.
- **Saturation**
  - Applies when `hi_cnt` or `lo_cnt` is at 2^CNT_W−1 and would increment (stuck input).
  - Pulse `err`, clear `locked` and `match_cnt`, return to ARM.
  - Length outputs hold their last values, and no `period_vld` is issued.
- `balanced` and `is_odd` update only with `period_vld` and hold in between.

## Timing
- **Reset values:** every output is 0, state is ARM, counters are 0. Reset takes effect asynchronously, including mid-period.
- **Latency:** `period_vld` is high in the cycle after the edge that sampled the first `s=1` of the next period. `high_len`, `low_len`, `period`, `is_odd` and `balanced` are valid in that same cycle.
- **First report after reset:** at the end of the first full period that follows the first 0→1 seen after ARM. The partial period is never reported.
- **Reset release:** deasserting `rst` lets the FSM run on the next `clk` edge.
- **Minimum period:** a 1-high/1-low waveform reports period=2 every 2 cycles. Back-to-back `period_vld` pulses are never adjacent.
- **Simultaneous events:** if a period mismatch and saturation could coincide, saturation wins. Saturation cannot coincide with a period completion.

## Structure
- **Package `odd_change_pkg`:** the FSM state enum (ARM/SYNC/HIGH/LOW) and the default `CNT_W`/`LOCK_N` constants, shared with the divider and the bench.
- **Sub-module `odd_lock_track`:** holds `match_cnt`, the previous period, `locked` and the mismatch `err`. It is driven by `period_vld` and `period`.
- The top level contains the FSM, the counters, saturation handling and the output registers.

## Test plan
- **Divide-by-3**, `din` sampled as 1,1,0 repeating → `high_len=2`, `low_len=1`, `period=3`, `is_odd=1`, `balanced=1`, `period_vld` every 3 cycles.
- **Divide-by-5**, `din` as 1,1,1,0,0 → `period=5`, `balanced=1`. `locked` rises with the 4th consecutive `period_vld` (LOCK_N=4), not before.
- **Period change after lock:** locked on period 5, then one period of 7 (1×4, 0×3) → `err` pulse and `locked=0` on that `period_vld`. Four more periods of 7 → relock.
- **Stuck input:** `din` held at 1 for 300 cycles with CNT_W=8 → `err` pulse at `hi_cnt` 255, `locked=0`, no `period_vld`. Resumed divide-by-3 → first report comes after the ARM/SYNC resync.
- **Reset mid-operation:** pull `rst` low mid-HIGH → all outputs are 0 immediately. After release, with `din` starting high, the first partial period is not reported.
- **Unbalanced duty:** 1,0,0,0,0 → `period=5`, `is_odd=1`, `balanced=0`.

Source files
------------

// File: rtl/odd_change_pkg.sv
// ----------------------------------------------------------------------------
// odd_change_pkg
// Shared definitions for the odd-ratio divider measurement path.
//   state_e      : receive FSM states (ARM, SYNC, HIGH, LOW)
//   DEF_CNT_W    : default phase counter width
//   DEF_LOCK_N   : default number of identical periods needed for lock
//   withinOne()  : true when two lengths differ by at most one cycle
// ----------------------------------------------------------------------------
package odd_change_pkg;

   typedef enum logic [1:0] {
      ARM  = 2'd0,
      SYNC = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } state_e;

   localparam int DEF_CNT_W  = 8;
   localparam int DEF_LOCK_N = 4;

   // Absolute-difference test done on wide unsigned values so callers of any
   // counter width can zero-extend into it without worrying about wraparound.
   function automatic logic withinOne(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] diff;
      diff = (a >= b) ? (a - b) : (b - a);
      return (diff <= 32'd1);
   endfunction

endpackage

// File: rtl/odd_lock_track.sv
// ----------------------------------------------------------------------------
// odd_lock_track
// Decides whether the measured period is stable and flags period changes
// that happen while stable.
//   clk_i     : system clock
//   rst_ni    : asynchronous active-low reset
//   vld_i     : a period completes on this edge
//   clr_i     : drop lock and restart the match count (counter saturation)
//   period_i  : length of the period completing on this edge
//   locked_o  : LOCK_N identical periods seen in a row
//   err_o     : one-cycle pulse when a different period arrives while locked
// ----------------------------------------------------------------------------
module odd_lock_track
   import odd_change_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int LOCK_N = DEF_LOCK_N
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             vld_i,
   input  logic             clr_i,
   input  logic [CNT_W:0]   period_i,
   output logic             locked_o,
   output logic             err_o
);

   localparam logic [3:0] LOCK_TGT = 4'(LOCK_N);

   logic [CNT_W:0] prevPeriod_q;
   logic [3:0]     matchCnt_q;
   logic [3:0]     matchCnt_d;
   logic           mismatch_d;
   logic           locked_q;
   logic           err_q;

   // Work out what the match counter becomes if the incoming period is
   // accepted: a different period restarts the run at one, an identical one
   // extends the run but never past the lock target.
   always_comb begin
      mismatch_d = (period_i != prevPeriod_q);
      matchCnt_d = matchCnt_q;
      if (mismatch_d) begin
         matchCnt_d = 4'd1;
      end else if (matchCnt_q < LOCK_TGT) begin
         matchCnt_d = matchCnt_q + 4'd1;
      end
   end

   // Lock state only moves on completed periods, so locked and the mismatch
   // error line up with the period report. The previous period survives a
   // saturation clear; the restarted match count makes that harmless.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prevPeriod_q <= '0;
         matchCnt_q   <= '0;
         locked_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (clr_i) begin
            matchCnt_q <= '0;
            locked_q   <= 1'b0;
         end else if (vld_i) begin
            prevPeriod_q <= period_i;
            matchCnt_q   <= matchCnt_d;
            locked_q     <= (matchCnt_d == LOCK_TGT);
            err_q        <= mismatch_d & locked_q;
         end
      end
   end

   assign locked_o = locked_q;
   assign err_o    = err_q;

endmodule

// File: rtl/odd_change_monitor.sv
// ----------------------------------------------------------------------------
// odd_change_monitor
// Measures the high phase, low phase and total length of each period of the
// divided waveform, and reports parity, duty balance and period lock.
//   clk_i         : system clock, everything on the rising edge
//   rst_ni        : asynchronous active-low reset
//   din_i         : divided waveform, already in the clk_i domain
//   high_len_o    : high-phase length of the last completed period
//   low_len_o     : low-phase length of the last completed period
//   period_o      : high_len_o + low_len_o, one bit wider so it never wraps
//   period_vld_o  : one-cycle pulse when the length outputs update
//   is_odd_o      : period_o[0]
//   balanced_o    : high and low phases differ by at most one cycle
//   locked_o      : period has been stable for LOCK_N periods
//   err_o         : pulse on a period change while locked, or on saturation
// ----------------------------------------------------------------------------
module odd_change_monitor
   import odd_change_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int LOCK_N = DEF_LOCK_N
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             din_i,
   output logic [CNT_W-1:0] high_len_o,
   output logic [CNT_W-1:0] low_len_o,
   output logic [CNT_W:0]   period_o,
   output logic             period_vld_o,
   output logic             is_odd_o,
   output logic             balanced_o,
   output logic             locked_o,
   output logic             err_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q;
   logic [CNT_W-1:0] hiCnt_q;
   logic [CNT_W-1:0] loCnt_q;
   logic [CNT_W-1:0] highLen_q;
   logic [CNT_W-1:0] lowLen_q;
   logic [CNT_W:0]   period_q;
   logic             periodVld_q;
   logic             isOdd_q;
   logic             balanced_q;
   logic             satErr_q;

   logic             done_d;
   logic             satHit_d;
   logic [CNT_W:0]   period_d;
   logic             balanced_d;
   logic             trackErr;

   // Decode the events of this edge. A period completes on the first high
   // sample after a low phase; saturation is a counter already at its
   // maximum that the current sample would push further. The two can never
   // happen together because completion needs a level change.
   always_comb begin
      done_d     = (state_q == LOW) && din_i;
      satHit_d   = ((state_q == HIGH) &&  din_i && (hiCnt_q == CNT_MAX)) ||
                   ((state_q == LOW)  && !din_i && (loCnt_q == CNT_MAX));
      period_d   = {1'b0, hiCnt_q} + {1'b0, loCnt_q};
      balanced_d = withinOne(32'(hiCnt_q), 32'(loCnt_q));
   end

   // Receive FSM with its phase counters and the report registers. ARM
   // throws away whatever high phase was in progress at reset or after a
   // saturation, SYNC waits for a clean rising edge, and from then on every
   // rising edge closes one period and opens the next. Saturation sends the
   // FSM back to ARM while the last good report stays on the outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ARM;
         hiCnt_q     <= '0;
         loCnt_q     <= '0;
         highLen_q   <= '0;
         lowLen_q    <= '0;
         period_q    <= '0;
         periodVld_q <= 1'b0;
         isOdd_q     <= 1'b0;
         balanced_q  <= 1'b0;
         satErr_q    <= 1'b0;
      end else begin
         periodVld_q <= 1'b0;
         satErr_q    <= 1'b0;
         if (satHit_d) begin
            satErr_q <= 1'b1;
            state_q  <= ARM;
            hiCnt_q  <= '0;
            loCnt_q  <= '0;
         end else begin
            case (state_q)
               ARM: begin
                  if (!din_i) begin
                     state_q <= SYNC;
                  end
               end
               SYNC: begin
                  if (din_i) begin
                     state_q <= HIGH;
                     hiCnt_q <= CNT_ONE;
                     loCnt_q <= '0;
                  end
               end
               HIGH: begin
                  if (din_i) begin
                     hiCnt_q <= hiCnt_q + CNT_ONE;
                  end else begin
                     state_q <= LOW;
                     loCnt_q <= CNT_ONE;
                  end
               end
               LOW: begin
                  if (!din_i) begin
                     loCnt_q <= loCnt_q + CNT_ONE;
                  end else begin
                     highLen_q   <= hiCnt_q;
                     lowLen_q    <= loCnt_q;
                     period_q    <= period_d;
                     isOdd_q     <= period_d[0];
                     balanced_q  <= balanced_d;
                     periodVld_q <= 1'b1;
                     hiCnt_q     <= CNT_ONE;
                     loCnt_q     <= '0;
                     state_q     <= HIGH;
                  end
               end
               default: begin
                  state_q <= ARM;
               end
            endcase
         end
      end
   end

   // Lock tracking sees the period on the same edge that the report is
   // registered, so locked and the mismatch error land with period_vld.
   odd_lock_track #(
      .CNT_W  (CNT_W),
      .LOCK_N (LOCK_N)
   ) u_lock (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .vld_i    (done_d),
      .clr_i    (satHit_d),
      .period_i (period_d),
      .locked_o (locked_o),
      .err_o    (trackErr)
   );

   assign high_len_o   = highLen_q;
   assign low_len_o    = lowLen_q;
   assign period_o     = period_q;
   assign period_vld_o = periodVld_q;
   assign is_odd_o     = isOdd_q;
   assign balanced_o   = balanced_q;
   assign err_o        = satErr_q | trackErr;

endmodule

// File: tb/tb_odd_change_monitor.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_odd_change_monitor
// Drives divided waveforms into odd_change_monitor and compares every cycle
// against a run-length model of the measurement rules, plus targeted checks
// for lock timing, period change, stuck input, reset and duty balance.
// ----------------------------------------------------------------------------
module tb_odd_change_monitor;
   import odd_change_pkg::*;

   localparam int CW   = DEF_CNT_W;
   localparam int LN   = DEF_LOCK_N;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          din = 1'b1;
   logic [CW-1:0] high_len;
   logic [CW-1:0] low_len;
   logic [CW:0]   period;
   logic          period_vld;
   logic          is_odd;
   logic          balanced;
   logic          locked;
   logic          err;

   int checks = 0;
   int errors = 0;

   odd_change_monitor #(.CNT_W(CW), .LOCK_N(LN)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .din_i        (din),
      .high_len_o   (high_len),
      .low_len_o    (low_len),
      .period_o     (period),
      .period_vld_o (period_vld),
      .is_odd_o     (is_odd),
      .balanced_o   (balanced),
      .locked_o     (locked),
      .err_o        (err)
   );

   // System clock, 10 ns period.
   always #5 clk = ~clk;

   logic [29:0] dutVec;
   assign dutVec = {high_len, low_len, period, period_vld, is_odd, balanced, locked, err};

   // Reference model: tracks runs of equal samples. A period is a high run
   // followed by a low run, reported when the next high run begins. Lock is
   // the last LN reported periods (since reset or saturation) being equal.
   int  expHigh, expLow, expPeriod;
   bit  expVld, expOdd, expBal, expLocked, expErr;
   bit  gotZero, started, lastS;
   int  runLen;
   int  runs[$];
   int  hist[$];

   function automatic void modelReset();
      expHigh = 0; expLow = 0; expPeriod = 0;
      expVld = 0; expOdd = 0; expBal = 0; expLocked = 0; expErr = 0;
      gotZero = 0; started = 0; lastS = 0; runLen = 0;
      runs.delete();
      hist.delete();
   endfunction

   function automatic void modelReport(int h, int l);
      int  p;
      bit  same;
      p = h + l;
      expHigh = h; expLow = l; expPeriod = p;
      expOdd = (p % 2) == 1;
      expBal = ((h > l) ? (h - l) : (l - h)) <= 1;
      expVld = 1;
      if (expLocked && hist.size() > 0 && p != hist[$]) expErr = 1;
      hist.push_back(p);
      if (hist.size() > LN) void'(hist.pop_front());
      same = (hist.size() == LN);
      foreach (hist[k]) if (hist[k] != hist[0]) same = 0;
      expLocked = same;
   endfunction

   function automatic void modelStep(bit s);
      expVld = 0;
      expErr = 0;
      if (!gotZero) begin
         if (!s) gotZero = 1;
      end else if (!started) begin
         if (s) begin
            started = 1; lastS = 1; runLen = 1;
            runs.delete();
         end
      end else if (s == lastS) begin
         runLen++;
         if (runLen > MAXC) begin
            expErr = 1; expLocked = 0;
            gotZero = 0; started = 0;
            runs.delete();
            hist.delete();
         end
      end else begin
         runs.push_back(runLen);
         runLen = 1;
         lastS = s;
         if (s) begin
            modelReport(runs[0], runs[1]);
            runs.delete();
         end
      end
   endfunction

   function automatic logic [29:0] expVec();
      return {8'(expHigh), 8'(expLow), 9'(expPeriod), expVld, expOdd, expBal, expLocked, expErr};
   endfunction

   // One sample: set din away from the edge, let the DUT and model take it,
   // then look at the outputs 1 ns after the edge.
   task automatic drive(input bit v);
      din = v;
      @(posedge clk);
      modelStep(v);
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      modelReset();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      modelReset();
      #2;
      if (dutVec !== 30'd0) begin
         errors++; $display("[TB] FAIL reset_outputs: got %h want %h", dutVec, 30'd0);
      end
      checks++;
      doReset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1);
         if (dutVec !== expVec()) begin
            errors++; $display("[TB] FAIL reset_idle%0d: got %h want %h", i, dutVec, expVec());
         end
         checks++;
      end
   endtask

   task automatic test_div3();
      bit pat[3] = '{1'b1, 1'b1, 1'b0};
      int lastVld = -1;
      int cyc = 0;
      int vlds = 0;
      for (int n = 0; n < 10; n++) begin
         for (int k = 0; k < 3; k++) begin
            drive(pat[k]);
            if (dutVec !== expVec()) begin
               errors++; $display("[TB] FAIL div3_cycle%0d: got %h want %h", cyc, dutVec, expVec());
            end
            checks++;
            if (period_vld === 1'b1) begin
               vlds++;
               if (lastVld >= 0) begin
                  if (cyc - lastVld !== 3) begin
                     errors++; $display("[TB] FAIL div3_spacing: got %0d want 3", cyc - lastVld);
                  end
                  checks++;
               end
               lastVld = cyc;
            end
            cyc++;
         end
      end
      if ({high_len, low_len, period, is_odd, balanced} !== {8'd2, 8'd1, 9'd3, 1'b1, 1'b1}) begin
         errors++; $display("[TB] FAIL div3_values: got h%0d l%0d p%0d o%b b%b want h2 l1 p3 o1 b1",
                            high_len, low_len, period, is_odd, balanced);
      end
      checks++;
      if (vlds < 8) begin
         errors++; $display("[TB] FAIL div3_count: got %0d want at least 8", vlds);
      end
      checks++;
   endtask

   task automatic test_div5_lock();
      bit pat[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      int vlds = 0;
      doReset();
      for (int n = 0; n < 8; n++) begin
         for (int k = 0; k < 5; k++) begin
            drive(pat[k]);
            if (dutVec !== expVec()) begin
               errors++; $display("[TB] FAIL div5_cycle%0d_%0d: got %h want %h", n, k, dutVec, expVec());
            end
            checks++;
            if (period_vld === 1'b1) begin
               vlds++;
               if (locked !== (vlds >= 4) || period !== 9'd5 || balanced !== 1'b1) begin
                  errors++; $display("[TB] FAIL div5_lock_vld%0d: got lk%b p%0d b%b want lk%b p5 b1",
                                     vlds, locked, period, balanced, vlds >= 4);
               end
               checks++;
            end
         end
      end
   endtask

   task automatic test_change_after_lock();
      bit pat[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      int vlds = 0;
      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k < 7; k++) begin
            if (n == 5 && k > 0) break;
            drive(pat[k]);
            if (dutVec !== expVec()) begin
               errors++; $display("[TB] FAIL change_cycle%0d_%0d: got %h want %h", n, k, dutVec, expVec());
            end
            checks++;
            if (period_vld === 1'b1) begin
               vlds++;
               if (vlds == 2) begin
                  if ({err, locked, period} !== {1'b1, 1'b0, 9'd7}) begin
                     errors++; $display("[TB] FAIL change_err: got e%b lk%b p%0d want e1 lk0 p7", err, locked, period);
                  end
                  checks++;
               end
            end
         end
      end
      if (locked !== 1'b1 || period !== 9'd7) begin
         errors++; $display("[TB] FAIL change_relock: got lk%b p%0d want lk1 p7", locked, period);
      end
      checks++;
   endtask

   task automatic test_stuck();
      bit pat[3] = '{1'b1, 1'b1, 1'b0};
      int errs = 0;
      int vlds = 0;
      int firstVld = -1;
      for (int i = 0; i < 300; i++) begin
         drive(1'b1);
         if (dutVec !== expVec()) begin
            errors++; $display("[TB] FAIL stuck_cycle%0d: got %h want %h", i, dutVec, expVec());
         end
         checks++;
         if (err === 1'b1) errs++;
         if (period_vld === 1'b1) vlds++;
      end
      if (errs !== 1 || vlds !== 0 || locked !== 1'b0 || period !== 9'd7) begin
         errors++; $display("[TB] FAIL stuck_summary: got err%0d vld%0d lk%b p%0d want err1 vld0 lk0 p7",
                            errs, vlds, locked, period);
      end
      checks++;
      for (int i = 0; i < 18; i++) begin
         drive(pat[i % 3]);
         if (dutVec !== expVec()) begin
            errors++; $display("[TB] FAIL resync_cycle%0d: got %h want %h", i, dutVec, expVec());
         end
         checks++;
         if (period_vld === 1'b1 && firstVld < 0) firstVld = i;
      end
      if (firstVld !== 6) begin
         errors++; $display("[TB] FAIL resync_first: got %0d want 6", firstVld);
      end
      checks++;
   endtask

   task automatic test_unbalanced();
      bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k < 5; k++) begin
            drive(pat[k]);
            if (dutVec !== expVec()) begin
               errors++; $display("[TB] FAIL unbal_cycle%0d_%0d: got %h want %h", n, k, dutVec, expVec());
            end
            checks++;
         end
      end
      if ({high_len, low_len, period, is_odd, balanced} !== {8'd1, 8'd4, 9'd5, 1'b1, 1'b0}) begin
         errors++; $display("[TB] FAIL unbal_values: got h%0d l%0d p%0d o%b b%b want h1 l4 p5 o1 b0",
                            high_len, low_len, period, is_odd, balanced);
      end
      checks++;
   endtask

   task automatic test_back_to_back();
      bit prevVld = 1'b0;
      for (int i = 0; i < 20; i++) begin
         drive(i[0] ? 1'b0 : 1'b1);
         if (dutVec !== expVec()) begin
            errors++; $display("[TB] FAIL min_cycle%0d: got %h want %h", i, dutVec, expVec());
         end
         checks++;
         if (prevVld && period_vld) begin
            errors++; $display("[TB] FAIL min_adjacent: got two adjacent pulses at %0d want gap", i);
         end
         prevVld = period_vld;
      end
      if (period !== 9'd2 || is_odd !== 1'b0 || locked !== 1'b1) begin
         errors++; $display("[TB] FAIL min_values: got p%0d o%b lk%b want p2 o0 lk1", period, is_odd, locked);
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      bit pat[3] = '{1'b1, 1'b1, 1'b0};
      int firstVld = -1;
      for (int i = 0; i < 10; i++) drive(pat[i % 3]);
      #2;
      rst_n = 1'b0;
      #1;
      if (dutVec !== 30'd0) begin
         errors++; $display("[TB] FAIL midreset_async: got %h want %h", dutVec, 30'd0);
      end
      checks++;
      @(posedge clk);
      #1;
      modelReset();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(pat[i % 3]);
         if (dutVec !== expVec()) begin
            errors++; $display("[TB] FAIL midreset_cycle%0d: got %h want %h", i, dutVec, expVec());
         end
         checks++;
         if (period_vld === 1'b1 && firstVld < 0) firstVld = i;
      end
      if (firstVld !== 6) begin
         errors++; $display("[TB] FAIL midreset_first: got %0d want 6", firstVld);
      end
      checks++;
   endtask

   task automatic test_random();
      int h, l, reps;
      for (int seg = 0; seg < 25; seg++) begin
         h    = $urandom_range(1, 6);
         l    = $urandom_range(1, 6);
         reps = $urandom_range(1, 6);
         for (int r = 0; r < reps; r++) begin
            for (int k = 0; k < h + l; k++) begin
               drive(k < h);
               if (dutVec !== expVec()) begin
                  errors++; $display("[TB] FAIL random_seg%0d: got %h want %h", seg, dutVec, expVec());
               end
               checks++;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_div3();
      test_div5_lock();
      test_change_after_lock();
      test_stuck();
      test_unbalanced();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net in case the run ever stops advancing.
   initial begin
      #2000000;
      errors++;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
